// File: rtl/eq_sample_scheduler.sv
// Per-sample sequencer for the three-band equalizer: captures an ADC sample, strobes the
// filter bank once, collects the result after LATENCY cycles and offers it to the DAC.
module eq_sample_scheduler #(
    parameter int p       = 8,
    parameter int f       = 14,
    parameter int Width   = p + f + 1,
    parameter int LATENCY = 2
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             adc_valid,
    input  logic [Width-1:0] adc_data,
    output logic [Width-1:0] arith_in,
    output logic             arith_enable,
    input  logic [Width-1:0] arith_out,
    output logic [Width-1:0] dac_data,
    output logic             dac_valid,
    input  logic             dac_ready,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_sel,
    input  logic [1:0]       cfg_gain,
    output logic [1:0]       gain1,
    output logic [1:0]       gain2,
    output logic [1:0]       gain3,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic [7:0]       overrun_cnt,
    output logic [1:0]       dbg_state
);

    // dac_valid/dac_ready: dac_data is offered while dac_valid is high and is held
    // unchanged until a cycle with dac_valid && dac_ready, which completes the transfer.

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [1:0]      sh1, sh2, sh3;
    logic [1:0]      sh1_nxt, sh2_nxt, sh3_nxt;
    logic            capture, drop;

    assign dbg_state = state;
    assign capture   = (state == S_IDLE) && adc_valid;
    assign drop      = (state != S_IDLE) && adc_valid;

    always_ff @(posedge sclk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        arith_enable = 1'b0;
        dac_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (adc_valid) state_nxt = S_FIRE;
            end
            S_FIRE: begin
                arith_enable = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == CW'(1)) state_nxt = S_OUT;
            end
            S_OUT: begin
                dac_valid = 1'b1;
                if (dac_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A write landing on the capture edge must be the value committed, so commit from the next-shadow.
    always_comb begin
        sh1_nxt = (cfg_wr && cfg_sel == 2'd1) ? cfg_gain : sh1;
        sh2_nxt = (cfg_wr && cfg_sel == 2'd2) ? cfg_gain : sh2;
        sh3_nxt = (cfg_wr && cfg_sel == 2'd3) ? cfg_gain : sh3;
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            arith_in    <= '0;
            dac_data    <= '0;
            wait_cnt    <= '0;
            sh1         <= 2'b00;
            sh2         <= 2'b00;
            sh3         <= 2'b00;
            gain1       <= 2'b00;
            gain2       <= 2'b00;
            gain3       <= 2'b00;
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            sh1 <= sh1_nxt;
            sh2 <= sh2_nxt;
            sh3 <= sh3_nxt;
            if (capture) begin
                arith_in <= adc_data;
                gain1    <= sh1_nxt;
                gain2    <= sh2_nxt;
                gain3    <= sh3_nxt;
            end
            if (state == S_FIRE)
                wait_cnt <= CW'(LATENCY);
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt - CW'(1);
            if (state == S_WAIT && wait_cnt == CW'(1))
                dac_data <= arith_out;
            if (ovr_clr) begin
                overrun     <= drop;
                overrun_cnt <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                overrun <= 1'b1;
                if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_eq_sample_scheduler.sv
// Bench for eq_sample_scheduler: directed stimulus, a cycle-timeline reference model
// checked every cycle, and literal expectations at key points.
module tb_eq_sample_scheduler;

    localparam int W   = 23;
    localparam int LAT = 2;
    localparam logic [W-1:0] JUNK = 23'h2A5A5A;

    logic         sclk = 1'b0;
    logic         rst = 1'b0;
    logic         adc_valid = 1'b0;
    logic [W-1:0] adc_data = '0;
    logic [W-1:0] arith_in, arith_out, dac_data;
    logic         arith_enable, dac_valid, busy, overrun;
    logic         dac_ready = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [1:0]   cfg_sel = 2'd0, cfg_gain = 2'd0;
    logic [1:0]   gain1, gain2, gain3, dbg_state;
    logic         ovr_clr = 1'b0;
    logic [7:0]   overrun_cnt;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    eq_sample_scheduler #(.p(8), .f(14), .Width(W), .LATENCY(LAT)) dut (
        .sclk(sclk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .arith_in(arith_in), .arith_enable(arith_enable), .arith_out(arith_out),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_gain(cfg_gain),
        .gain1(gain1), .gain2(gain2), .gain3(gain3), .busy(busy),
        .overrun(overrun), .ovr_clr(ovr_clr), .overrun_cnt(overrun_cnt),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 sclk = ~sclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Datapath stand-in: result equals the enabled sample, valid exactly LAT cycles later, junk otherwise.
    logic [W-1:0] dp1 = JUNK, dp2 = JUNK;
    always @(posedge sclk) begin
        dp1 <= arith_enable ? arith_in : JUNK;
        dp2 <= dp1;
    end
    assign arith_out = dp2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a sample's life is tracked as its age in cycles since acceptance.
    bit           m_init = 0;
    bit           m_busy = 0;
    int           m_age = 0;
    logic [W-1:0] m_in = '0, m_dac = '0;
    logic [1:0]   m_sh[1:3];
    logic [1:0]   m_g[1:3];
    bit           m_ovr = 0;
    int           m_cnt = 0;

    initial begin
        for (int i = 1; i <= 3; i++) begin
            m_sh[i] = 2'b00;
            m_g[i]  = 2'b00;
        end
    end

    always @(negedge sclk) begin
        if (m_init) begin
            check("enable",   32'(arith_enable), 32'(m_busy && m_age == 1));
            check("dvalid",   32'(dac_valid),    32'(m_busy && m_age >= 2 + LAT));
            check("busy",     32'(busy),         32'(m_busy));
            check("arith_in", 32'(arith_in),     32'(m_in));
            check("dac_data", 32'(dac_data),     32'(m_dac));
            check("gain1",    32'(gain1),        32'(m_g[1]));
            check("gain2",    32'(gain2),        32'(m_g[2]));
            check("gain3",    32'(gain3),        32'(m_g[3]));
            check("ovr",      32'(overrun),      32'(m_ovr));
            check("ovr_cnt",  32'(overrun_cnt),  32'(m_cnt));
            if (dac_valid && dac_ready) xfers++;
        end
        if (!rst) begin
            m_init = 1; m_busy = 0; m_age = 0; m_in = '0; m_dac = '0;
            m_ovr = 0; m_cnt = 0;
            for (int i = 1; i <= 3; i++) begin
                m_sh[i] = 2'b00;
                m_g[i]  = 2'b00;
            end
        end else begin
            if (cfg_wr && cfg_sel != 2'd0) m_sh[cfg_sel] = cfg_gain;
            if (adc_valid && m_busy) begin
                m_ovr = 1;
                m_cnt = ovr_clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
            end else if (ovr_clr) begin
                m_ovr = 0;
                m_cnt = 0;
            end
            if (!m_busy) begin
                if (adc_valid) begin
                    m_busy = 1; m_age = 1; m_in = adc_data;
                    for (int i = 1; i <= 3; i++) m_g[i] = m_sh[i];
                end
            end else if (m_age >= 2 + LAT) begin
                if (dac_ready) m_busy = 0;
            end else begin
                m_age++;
                if (m_age == 2 + LAT) m_dac = m_in;
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    int base;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_arith_in", 32'(arith_in), 32'd0);
        check("rst_dac_data", 32'(dac_data), 32'd0);
        check("rst_flags", {28'd0, arith_enable, dac_valid, busy, overrun}, 32'd0);
        check("rst_cnt", 32'(overrun_cnt), 32'd0);
        check("rst_gains", {26'd0, gain1, gain2, gain3}, 32'd0);
        rst = 1'b1;
        dac_ready = 1'b1;
        tick();

        // Single sample
        send(23'h400000);
        check("s1_enable_c1", 32'(arith_enable), 32'd1);
        check("s1_busy_c1", 32'(busy), 32'd1);
        tick();
        check("s1_enable_c2", 32'(arith_enable), 32'd0);
        tick();
        check("s1_dvalid_c3", 32'(dac_valid), 32'd0);
        tick();
        check("s1_dvalid_c4", 32'(dac_valid), 32'd1);
        check("s1_data_c4", 32'(dac_data), 32'h400000);
        tick();
        check("s1_dvalid_c5", 32'(dac_valid), 32'd0);
        check("s1_busy_c5", 32'(busy), 32'd0);
        tick();

        // Back-pressure
        dac_ready = 1'b0;
        base = xfers;
        send(23'h123456);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 32'(dac_valid), 32'd1);
            check("bp_hold_data", 32'(dac_data), 32'h123456);
            tick();
        end
        dac_ready = 1'b1;
        tick();
        check("bp_released", 32'(dac_valid), 32'd0);
        check("bp_one_xfer", 32'(xfers - base), 32'd1);
        tick();

        // Overrun: pulses every 2 cycles against a 5-cycle period
        base = xfers;
        for (int i = 0; i < 10; i++) begin
            send(23'h010000 + 23'(i));
            tick();
        end
        repeat (4) tick();
        check("ovr_cnt_6", 32'(overrun_cnt), 32'd6);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_xfers_4", 32'(xfers - base), 32'd4);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr_cnt", 32'(overrun_cnt), 32'd0);
        check("ovr_clr_flag", 32'(overrun), 32'd0);

        // Saturation: one accepted sample then 300 drops during a stall
        dac_ready = 1'b0;
        adc_data  = 23'h055555;
        adc_valid = 1'b1;
        repeat (301) tick();
        check("ovr_sat", 32'(overrun_cnt), 32'd255);
        ovr_clr = 1'b1;
        tick();
        check("ovr_clr_drop_cnt", 32'(overrun_cnt), 32'd1);
        check("ovr_clr_drop_flag", 32'(overrun), 32'd1);
        adc_valid = 1'b0;
        ovr_clr   = 1'b0;
        dac_ready = 1'b1;
        repeat (2) tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;

        // Gain write while a sample is in flight
        send(23'h0ABCDE);
        tick();
        cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_gain = 2'd3;
        tick();
        cfg_wr = 1'b0;
        check("gain_inflight", 32'(gain2), 32'd0);
        repeat (3) tick();
        check("gain_idle_held", 32'(gain2), 32'd0);
        send(23'h135790);
        check("gain_committed", 32'(gain2), 32'd3);
        repeat (4) tick();
        // Write coinciding with the capture
        cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_gain = 2'd2;
        send(23'h024680);
        cfg_wr = 1'b0;
        check("gain_same_cycle", 32'(gain2), 32'd2);
        repeat (4) tick();
        // cfg_sel=0 is ignored
        cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_gain = 2'd3;
        tick();
        cfg_wr = 1'b0;
        send(23'h00FACE);
        check("gain_sel0", {26'd0, gain1, gain2, gain3}, {26'd0, 2'd0, 2'd2, 2'd0});
        repeat (4) tick();

        // Reset mid-sample, timed so it takes effect where dac_valid would rise
        send(23'h3C3C3C);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_dvalid", 32'(dac_valid), 32'd0);
        check("mid_rst_flags", {28'd0, arith_enable, dac_valid, busy, overrun}, 32'd0);
        check("mid_rst_data", 32'(dac_data), 32'd0);
        check("mid_rst_arith_in", 32'(arith_in), 32'd0);
        check("mid_rst_gains", {26'd0, gain1, gain2, gain3}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send(23'h7FFFFF);
        repeat (3) tick();
        check("post_rst_dvalid", 32'(dac_valid), 32'd1);
        check("post_rst_data", 32'(dac_data), 32'h7FFFFF);
        check("post_rst_gains", {26'd0, gain1, gain2, gain3}, 32'd0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eq_sample_scheduler.md
# eq_sample_scheduler

Per-sample sequencer for the three-band equalizer arithmetic datapath. It captures each ADC sample and issues the single-cycle `enable` strobe that advances the filter bank. After the datapath latency it captures the result and hands it to the DAC side with a valid/ready handshake. It also applies gain reconfiguration glitch-free, only at sample boundaries, and counts overruns. It sits between the ADC/DAC interface logic and the arithmetic top-level.

## Interface
- `p`, 8, integer bits of the fixed-point format
- `f`, 14, fractional bits
- `Width`, p+f+1, sample word width (signed)
- `LATENCY`, 2, cycles from the `arith_enable` cycle until `arith_out` is valid; must be ≥1
- `sclk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `sclk`; 0 = reset)
- `adc_valid`  in  1  one-cycle pulse: `adc_data` holds a new sample
- `adc_data`  in  Width  raw ADC sample (offset-binary, as fed to the datapath)
- `arith_in`  out  Width  registered sample presented to the datapath's `dato_adc`
- `arith_enable`  out  1  one-cycle advance strobe to the datapath
- `arith_out`  in  Width  datapath result (`dato_dac`)
- `dac_data`  out  Width  registered result for the DAC
- `dac_valid`  out  1  `dac_data` valid; held until accepted
- `dac_ready`  in  1  DAC side accepts when `dac_valid && dac_ready`
- `cfg_wr`  in  1  gain write strobe
- `cfg_sel`  in  2  1=bass, 2=mid, 3=high; 0 is ignored
- `cfg_gain`  in  2  gain code to write
- `gain1`, `gain2`, `gain3`  out  2 each  committed gain codes to the datapath
- `busy`  out  1  high in every state except IDLE
- `overrun`  out  1  sticky: a sample was dropped
- `ovr_clr`  in  1  clears `overrun` and `overrun_cnt`
- `overrun_cnt`  out  8  count of dropped samples, saturates at 255

## Operation
- **Reset values** (any cycle with `rst`=0): state IDLE; `arith_in`=0, `dac_data`=0; `arith_enable`, `dac_valid`, `busy`, `overrun` = 0; `overrun_cnt`=0; shadow gains and `gain1..3` = 2'b00.
- **IDLE**
  - On `adc_valid`: register `adc_data` into `arith_in` and copy the shadow gains into `gain1..3`.
  - Next state is FIRE.
- **FIRE**
  - `arith_enable`=1 for exactly this cycle.
  - Load the wait counter with `LATENCY`; next state is WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 1, register `arith_out` into `dac_data`; next state is OUT.
- **OUT**
  - `dac_valid`=1; `dac_data` is stable.
  - When `dac_ready`=1, the transfer completes this cycle; next state is IDLE and `dac_valid` is 0 from the next cycle.
- **Gain configuration**
  - `cfg_wr` with `cfg_sel`≠0 updates the matching shadow register in any state.
  - Shadow registers reach `gain1..3` only on the IDLE→FIRE capture edge. Gains therefore never change while a sample is in flight.
  - If `cfg_wr` coincides with a capture, the newly written value is the one committed.
  - `cfg_sel`=0 has no effect.
- **Overrun**
  - `adc_valid` in any state other than IDLE drops that sample.
  - On a drop, `overrun` is set and `overrun_cnt` increments, holding at 255.
  - `ovr_clr` alone clears both.
  - `ovr_clr` together with a drop gives `overrun`=1 and `overrun_cnt`=1.
- **Datapath contract**: `arith_in` and `gain1..3` are stable from the capture edge until the next capture. `arith_in` is treated as an opaque Width-bit word; no arithmetic is done in this block.

## Timing
- Sample accepted in cycle 0 (IDLE, `adc_valid`=1):
  - cycle 1: `arith_enable`=1
  - cycles 2 to 1+LATENCY: WAIT
  - cycle 2+LATENCY: first cycle with `dac_valid`=1
- With `dac_ready` tied high, the block is back in IDLE at cycle 3+LATENCY. The minimum sustainable sample period is LATENCY+3 cycles (5 at the default).
- A DAC stall extends OUT indefinitely. `adc_valid` pulses during the stall are counted as overruns.
- `busy` is a registered decode of the state, valid from cycle 1 of each sample.
- If `rst` is asserted mid-sample, the in-flight sample is discarded: `dac_valid` and `arith_enable` are low in the cycle after reset is sampled, and no partial result is delivered.

## Test plan
- **Single sample, default LATENCY=2, `dac_ready`=1.** Apply `adc_data`=23'h400000 in cycle 0; model `arith_out`=enable-delayed copy. Required: `arith_enable` high only in cycle 1, `dac_valid` high only in cycle 4, `dac_data`=23'h400000, `busy` low again in cycle 5.
- **Back-pressure.** Hold `dac_ready`=0 for 10 cycles after `dac_valid` rises. Required: `dac_data` and `dac_valid` stay constant for all 10 cycles, and exactly one transfer occurs after `dac_ready` rises.
- **Overrun.** Pulse `adc_valid` every 2 cycles for 20 cycles. Required: accepted and dropped samples match the 5-cycle period, and `overrun_cnt` equals the number of drops. After 300 forced drops, `overrun_cnt`=255. Assert `ovr_clr` together with a drop: `overrun_cnt`=1.
- **Gain timing.** Write `cfg_sel`=2, `cfg_gain`=3 during WAIT. Required: `gain2` unchanged until the next capture edge, then 3. Write in the same cycle as a capture: `gain2`=3 immediately. Write with `cfg_sel`=0: no gain changes.
- **Reset mid-operation.** Assert `rst`=0 in the cycle `dac_valid` would rise. Required: `dac_valid` never asserts, all outputs take their reset values, and a new sample after release completes normally with gains at 2'b00.
